// File: rtl/ahb_ext_mem_backend_if.sv
// External request/response interface between the AHB slave and its memory backend.
// The slave drives requests (master modport); the backend services them (slave modport).
interface ahb_ext_mem_backend_if #(
  parameter int AddresseWidth = 4,
  parameter int DataWidth     = 32
);
  logic                     Write;
  logic                     Read;
  logic [AddresseWidth-1:0] AddressOUT;
  logic [DataWidth-1:0]     OutputData;
  logic [DataWidth-1:0]     InData;
  logic                     ValidRead;
  logic                     WriteDone;
  logic                     StopOp;
  logic                     ReadyToWork;

  modport master (
    output Write, Read, AddressOUT, OutputData,
    input  InData, ValidRead, WriteDone, StopOp, ReadyToWork
  );

  modport slave (
    input  Write, Read, AddressOUT, OutputData,
    output InData, ValidRead, WriteDone, StopOp, ReadyToWork
  );
endinterface

// File: rtl/ahb_ext_mem_backend.sv
// Memory backend for the AHB slave's external interface: services one read or write at a
// time from an internal word memory after a fixed number of wait states.
module ahb_ext_mem_backend #(
  parameter int AddresseWidth = 4,
  parameter int DataWidth     = 32,
  parameter int MemDepth      = 16,
  parameter int WaitStates    = 2
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_ext_mem_backend_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam logic [3:0] WaitLoad = 4'(WaitStates);
  localparam bit         ZeroWait = (WaitStates == 0);

  state_t                   state;
  logic [3:0]               wait_cnt;
  logic [AddresseWidth-1:0] cap_addr;
  logic [DataWidth-1:0]     cap_data;
  logic                     cap_write;

  logic [DataWidth-1:0]     in_data_q;
  logic                     valid_read_q;
  logic                     write_done_q;
  logic                     stop_op_q;
  logic                     ready_q;

  logic [DataWidth-1:0]     mem [MemDepth];

  logic                     req_valid;
  logic                     req_err;
  logic                     in_range;
  logic                     enter_done;
  logic [AddresseWidth-1:0] acc_addr;
  logic [DataWidth-1:0]     acc_data;
  logic                     acc_write;

  // The access that completes on this edge: straight from the bus when there are no
  // wait states, otherwise from the captured request.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    in_range   = (32'(bus.AddressOUT) < 32'(MemDepth));
    req_valid  = (state == IDLE) && (bus.Write || bus.Read);
    req_err    = (bus.Write && bus.Read) || !in_range;
    enter_done = 1'b0;
    acc_addr   = cap_addr;
    acc_data   = cap_data;
    acc_write  = cap_write;
    if (state == IDLE) begin
      acc_addr   = bus.AddressOUT;
      acc_data   = bus.OutputData;
      acc_write  = bus.Write;
      enter_done = req_valid && !req_err && ZeroWait;
    end else if (state == BUSY) begin
      enter_done = (wait_cnt == 4'd1);
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cap_addr     <= '0;
      cap_data     <= '0;
      cap_write    <= 1'b0;
      in_data_q    <= '0;
      valid_read_q <= 1'b0;
      write_done_q <= 1'b0;
      stop_op_q    <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      valid_read_q <= 1'b0;
      write_done_q <= 1'b0;
      stop_op_q    <= 1'b0;

      if (enter_done) begin
        if (acc_write) begin
          write_done_q <= 1'b1;
        end else begin
          valid_read_q <= 1'b1;
          in_data_q    <= mem[acc_addr];
        end
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= bus.AddressOUT;
            cap_data  <= bus.OutputData;
            cap_write <= bus.Write;
            wait_cnt  <= WaitLoad;
            ready_q   <= 1'b0;
            if (req_err) begin
              state     <= ERR;
              stop_op_q <= 1'b1;
            end else if (ZeroWait) begin
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= DONE;
        end
        DONE, ERR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the memory is cleared by reset because a read after reset must return zero;
  // a reset-free RAM macro would not honour that.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MemDepth; i++) mem[i] <= '0;
    end else if (enter_done && acc_write) begin
      mem[acc_addr] <= acc_data;
    end
  end

  assign bus.InData      = in_data_q;
  assign bus.ValidRead   = valid_read_q;
  assign bus.WriteDone   = write_done_q;
  assign bus.StopOp      = stop_op_q;
  assign bus.ReadyToWork = ready_q;

endmodule

// File: tb/tb_ahb_ext_mem_backend.sv
// Bench for ahb_ext_mem_backend: two instances (2 wait states/16 words, 0 wait states/12
// words) checked every cycle against a cycle-scheduled transaction model plus literal checks.
module tb_ahb_ext_mem_backend;

  typedef struct packed {
    logic        rdy;
    logic        vr;
    logic        wd;
    logic        so;
    logic [31:0] rd;
  } obs_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [3:0]  a;
    logic [31:0] x;
  } req_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_ext_mem_backend_if #(.AddresseWidth(4), .DataWidth(32)) bus_a ();
  ahb_ext_mem_backend_if #(.AddresseWidth(4), .DataWidth(32)) bus_b ();

  ahb_ext_mem_backend #(.AddresseWidth(4), .DataWidth(32), .MemDepth(16), .WaitStates(2)) u_a (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus_a)
  );
  ahb_ext_mem_backend #(.AddresseWidth(4), .DataWidth(32), .MemDepth(12), .WaitStates(0)) u_b (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic string nm(input int d, input string s);
    return $sformatf("%s.%s", (d == 0) ? "ws2" : "ws0", s);
  endfunction

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) o = '{bus_a.ReadyToWork, bus_a.ValidRead, bus_a.WriteDone, bus_a.StopOp, bus_a.InData};
    else        o = '{bus_b.ReadyToWork, bus_b.ValidRead, bus_b.WriteDone, bus_b.StopOp, bus_b.InData};
    return o;
  endfunction

  function automatic req_t get_req(input int d);
    req_t r;
    if (d == 0) r = '{bus_a.Write, bus_a.Read, bus_a.AddressOUT, bus_a.OutputData};
    else        r = '{bus_b.Write, bus_b.Read, bus_b.AddressOUT, bus_b.OutputData};
    return r;
  endfunction

  task automatic drive(input int d, input logic wr, input logic rd, input logic [3:0] a,
                       input logic [31:0] x);
    if (d == 0) begin
      bus_a.Write = wr; bus_a.Read = rd; bus_a.AddressOUT = a; bus_a.OutputData = x;
    end else begin
      bus_b.Write = wr; bus_b.Read = rd; bus_b.AddressOUT = a; bus_b.OutputData = x;
    end
  endtask

  // Model: edges are numbered from reset release. A request accepted at edge k produces its
  // response in the cycle after edge k+WaitStates (error: after edge k) and the next request
  // can be taken at edge k+WaitStates+2 (error: k+2).
  int          cyc;
  int          m_next_acc   [2];
  int          m_resp_at    [2];
  int          m_err_at     [2];
  logic        m_resp_wr    [2];
  logic [3:0]  m_resp_addr  [2];
  logic [31:0] m_resp_wdata [2];
  logic [31:0] m_indata     [2];
  logic [31:0] m_mem        [2][16];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_next_acc[d]   = 0;
      m_resp_at[d]    = -100;
      m_err_at[d]     = -100;
      m_resp_wr[d]    = 1'b0;
      m_resp_addr[d]  = '0;
      m_resp_wdata[d] = '0;
      m_indata[d]     = '0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
    end
  endtask

  task automatic model_edge();
    req_t r;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      r = get_req(d);
      if (cyc >= m_next_acc[d] && (r.wr || r.rd)) begin
        if ((r.wr && r.rd) || int'(r.a) >= depth_of(d)) begin
          m_err_at[d]   = cyc;
          m_next_acc[d] = cyc + 2;
        end else begin
          m_resp_at[d]    = cyc + ws_of(d);
          m_resp_wr[d]    = r.wr;
          m_resp_addr[d]  = r.a;
          m_resp_wdata[d] = r.x;
          m_next_acc[d]   = cyc + ws_of(d) + 2;
        end
      end
      if (cyc == m_resp_at[d]) begin
        if (m_resp_wr[d]) m_mem[d][m_resp_addr[d]] = m_resp_wdata[d];
        else              m_indata[d] = m_mem[d][m_resp_addr[d]];
      end
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Per-cycle comparison of both instances against the model, mid-cycle.
  initial begin
    obs_t o;
    logic at_resp;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o       = sample(d);
        at_resp = (cyc == m_resp_at[d]);
        check(nm(d, "ReadyToWork"), o.rdy, (cyc >= m_next_acc[d] - 1));
        check(nm(d, "ValidRead"),   o.vr,  at_resp && !m_resp_wr[d]);
        check(nm(d, "WriteDone"),   o.wd,  at_resp && m_resp_wr[d]);
        check(nm(d, "StopOp"),      o.so,  (cyc == m_err_at[d]));
        check(nm(d, "InData"),      o.rd,  m_indata[d]);
      end
    end
  end

  // Issue one request right after a negedge with ReadyToWork=1. Returns the cycle offset
  // (after the accepting edge) of the first response pulse and of ReadyToWork returning.
  task automatic do_req(input int d, input logic wr, input logic rd, input logic [3:0] a,
                        input logic [31:0] x, output int lat, output int rdy_lat,
                        output obs_t pulse);
    obs_t o;
    lat     = 0;
    rdy_lat = 0;
    pulse   = '0;
    drive(d, wr, rd, a, x);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int n = 1; n <= 40; n++) begin
      o = sample(d);
      if (lat == 0 && (o.vr || o.wd || o.so)) begin
        lat   = n;
        pulse = o;
      end
      if (o.rdy) begin
        rdy_lat = n;
        break;
      end
      @(negedge clk);
    end
    check(nm(d, "ready_returned"), (rdy_lat != 0), 1'b1);
  endtask

  // Hold a read of address 1 for 16 cycles and check the service cadence.
  task automatic back_to_back(input int d, input logic [31:0] val, input int period,
                              input int exp_n);
    obs_t o;
    int   pq[$];
    int   rq[$];
    int   rdy_mid;
    drive(d, 1'b0, 1'b1, 4'd1, 32'd0);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      o = sample(d);
      if (o.vr) begin
        pq.push_back(n);
        check(nm(d, "b2b_data"), o.rd, val);
      end
      if (o.rdy) rq.push_back(n);
    end
    drive(d, 1'b0, 1'b0, 4'd0, 32'd0);
    check(nm(d, "b2b_count"), pq.size(), exp_n);
    for (int i = 1; i < pq.size(); i++) check(nm(d, "b2b_spacing"), pq[i] - pq[i-1], period);
    rdy_mid = 0;
    if (pq.size() > 1)
      foreach (rq[i]) if (rq[i] > pq[0] && rq[i] < pq[pq.size()-1]) rdy_mid++;
    check(nm(d, "b2b_ready_gaps"), rdy_mid, exp_n - 1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   lat;
    int   rl;

    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    o = sample(0);
    check("reset_ready", o.rdy, 1'b1);
    check("reset_pulses", {o.vr, o.wd, o.so}, 3'b000);
    check("reset_indata", o.rd, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read with two wait states.
    do_req(0, 1'b1, 1'b0, 4'd5, 32'hDEAD_BEEF, lat, rl, o);
    check("wr5_latency", lat, 3);
    check("wr5_ready", rl, 4);
    check("wr5_writedone", o.wd, 1'b1);
    do_req(0, 1'b0, 1'b1, 4'd5, 32'h0, lat, rl, o);
    check("rd5_latency", lat, 3);
    check("rd5_ready", rl, 4);
    check("rd5_validread", o.vr, 1'b1);
    check("rd5_data", o.rd, 32'hDEAD_BEEF);

    // Inputs changing during BUSY are ignored.
    drive(0, 1'b1, 1'b0, 4'd6, 32'h6666_0006);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd7, 32'h7777_0007);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'd6, 32'hBAD0_0006);
    @(negedge clk);
    o = sample(0);
    check("ign_writedone", o.wd, 1'b1);
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    o = sample(0);
    check("ign_ready", o.rdy, 1'b1);
    check("ign_no_extra", o.wd, 1'b0);
    do_req(0, 1'b0, 1'b1, 4'd6, 32'h0, lat, rl, o);
    check("ign_rd6", o.rd, 32'h6666_0006);
    do_req(0, 1'b0, 1'b1, 4'd7, 32'h0, lat, rl, o);
    check("ign_rd7", o.rd, 32'h0);

    // Highest address of a full-depth memory.
    do_req(0, 1'b1, 1'b0, 4'd15, 32'h0F0F_1515, lat, rl, o);
    check("wr15_writedone", o.wd, 1'b1);
    do_req(0, 1'b0, 1'b1, 4'd15, 32'h0, lat, rl, o);
    check("rd15_data", o.rd, 32'h0F0F_1515);

    // Reset in the middle of a write's BUSY phase.
    drive(0, 1'b1, 1'b0, 4'd3, 32'h0000_1234);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
    o = sample(0);
    check("rst_busy_ready", o.rdy, 1'b0);
    #2 rst_n = 1'b0;
    #1 o = sample(0);
    check("rst_async_ready", o.rdy, 1'b1);
    check("rst_async_pulses", {o.vr, o.wd, o.so}, 3'b000);
    check("rst_async_indata", o.rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 o = sample(0);
    check("rst_release_ready", o.rdy, 1'b1);
    @(negedge clk);
    do_req(0, 1'b0, 1'b1, 4'd3, 32'h0, lat, rl, o);
    check("rst_rd3_data", o.rd, 32'h0);
    check("rst_rd3_valid", o.vr, 1'b1);
    do_req(0, 1'b0, 1'b1, 4'd5, 32'h0, lat, rl, o);
    check("rst_rd5_cleared", o.rd, 32'h0);

    // Zero wait states, 12-word memory.
    do_req(1, 1'b1, 1'b0, 4'd0, 32'hA5A5_A5A5, lat, rl, o);
    check("ws0_wr_latency", lat, 1);
    check("ws0_wr_ready", rl, 2);
    do_req(1, 1'b0, 1'b1, 4'd0, 32'h0, lat, rl, o);
    check("ws0_rd_latency", lat, 1);
    check("ws0_rd_ready", rl, 2);
    check("ws0_rd_data", o.rd, 32'hA5A5_A5A5);

    do_req(1, 1'b0, 1'b1, 4'hD, 32'h0, lat, rl, o);
    check("err_range_latency", lat, 1);
    check("err_range_stop", {o.vr, o.wd, o.so}, 3'b001);
    check("err_range_indata", o.rd, 32'hA5A5_A5A5);
    do_req(1, 1'b1, 1'b0, 4'd12, 32'hC0C0_C0C0, lat, rl, o);
    check("err_depth_stop", {o.vr, o.wd, o.so}, 3'b001);
    do_req(1, 1'b1, 1'b0, 4'd11, 32'h1111_000B, lat, rl, o);
    check("last_word_wr", {o.vr, o.wd, o.so}, 3'b010);
    do_req(1, 1'b0, 1'b1, 4'd11, 32'h0, lat, rl, o);
    check("last_word_rd", o.rd, 32'h1111_000B);

    do_req(1, 1'b1, 1'b0, 4'd2, 32'h0000_0022, lat, rl, o);
    do_req(1, 1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, lat, rl, o);
    check("err_both_stop", {o.vr, o.wd, o.so}, 3'b001);
    check("err_both_ready", rl, 2);
    do_req(1, 1'b0, 1'b1, 4'd2, 32'h0, lat, rl, o);
    check("err_both_mem2", o.rd, 32'h0000_0022);

    // Back-to-back reads with the request held.
    do_req(0, 1'b1, 1'b0, 4'd1, 32'h0000_0111, lat, rl, o);
    back_to_back(0, 32'h0000_0111, 4, 4);
    do_req(1, 1'b1, 1'b0, 4'd1, 32'h0000_0BBB, lat, rl, o);
    back_to_back(1, 32'h0000_0BBB, 2, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
